// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard scoreboard
package hazard_pkg;

    localparam int REG_ADDR_W      = 5;
    localparam int STG_EX          = 0;
    localparam int STG_MEM         = 1;
    localparam int STG_WB          = 2;
    localparam int FWD_SEL_REGFILE = 0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_en;
        logic                  is_load;
    } trk_entry_t;

endpackage

// File: rtl/hazard_src_match.sv
// rtl/hazard_src_match.sv - youngest in-flight producer search for one source operand
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int ALU_READY  = STG_MEM,
    parameter int LOAD_READY = STG_WB,
    parameter int SEL_W      = 2
) (
    input  trk_entry_t [NUM_STAGES-1:0] trk,
    input  logic [REG_ADDR_W-1:0]       rs,
    input  logic                        rs_used,
    output logic                        found,
    output logic [SEL_W-1:0]            stage,
    output logic                        ready
);

    // Scan oldest to youngest so the lowest matching stage overwrites the rest.
    always_comb begin
        found = 1'b0;
        stage = '0;
        ready = 1'b0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (trk[k].valid && trk[k].reg_en && (trk[k].rd == rs) &&
                (rs != '0) && rs_used) begin
                found = 1'b1;
                stage = SEL_W'(k);
                ready = (k >= (trk[k].is_load ? LOAD_READY : ALU_READY));
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight destination tracker driving stall, bubble and bypass selects
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int ADDR_W     = REG_ADDR_W,
    parameter int ALU_READY  = STG_MEM,
    parameter int LOAD_READY = STG_WB,
    parameter int SEL_W      = $clog2(NUM_STAGES + 1),
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_reg_en,
    input  logic              id_is_load,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              flush_id,
    input  logic              mem_wait,
    input  logic              perf_clr,
    output logic              stall_if,
    output logic              bubble_ex,
    output logic [SEL_W-1:0]  fwd_a_sel,
    output logic [SEL_W-1:0]  fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  hazard_cnt
);

    trk_entry_t [NUM_STAGES-1:0] trk_q, trk_d;
    logic [CNT_W-1:0]            stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]            hazard_cnt_q, hazard_cnt_d;

    logic             a_found, a_ready, b_found, b_ready;
    logic [SEL_W-1:0] a_stage, b_stage;
    logic             hazard;

    hazard_src_match #(
        .NUM_STAGES(NUM_STAGES), .ALU_READY(ALU_READY),
        .LOAD_READY(LOAD_READY), .SEL_W(SEL_W)
    ) u_match_rs1 (
        .trk(trk_q), .rs(REG_ADDR_W'(id_rs1)), .rs_used(id_rs1_used),
        .found(a_found), .stage(a_stage), .ready(a_ready)
    );

    hazard_src_match #(
        .NUM_STAGES(NUM_STAGES), .ALU_READY(ALU_READY),
        .LOAD_READY(LOAD_READY), .SEL_W(SEL_W)
    ) u_match_rs2 (
        .trk(trk_q), .rs(REG_ADDR_W'(id_rs2)), .rs_used(id_rs2_used),
        .found(b_found), .stage(b_stage), .ready(b_ready)
    );

    // An unready producer leaves the select at the regfile: decode is held anyway.
    always_comb begin
        hazard    = id_valid && !flush_id &&
                    ((a_found && !a_ready) || (b_found && !b_ready));
        stall_if  = mem_wait || hazard;
        bubble_ex = hazard && !mem_wait;
        fwd_a_sel = (a_found && a_ready) ? a_stage + SEL_W'(1) : SEL_W'(FWD_SEL_REGFILE);
        fwd_b_sel = (b_found && b_ready) ? b_stage + SEL_W'(1) : SEL_W'(FWD_SEL_REGFILE);
    end

    always_comb begin
        trk_d = trk_q;
        if (!mem_wait) begin
            for (int k = 1; k < NUM_STAGES; k++) begin
                trk_d[k] = trk_q[k-1];
            end
            if (hazard || flush_id || !id_valid) begin
                trk_d[STG_EX] = '0;
            end else begin
                trk_d[STG_EX].valid   = 1'b1;
                trk_d[STG_EX].rd      = REG_ADDR_W'(id_rd);
                trk_d[STG_EX].reg_en  = id_reg_en;
                trk_d[STG_EX].is_load = id_is_load;
            end
        end
    end

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        hazard_cnt_d = hazard_cnt_q;
        if (perf_clr) begin
            stall_cnt_d  = '0;
            hazard_cnt_d = '0;
        end else begin
            if (stall_if && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (bubble_ex && (hazard_cnt_q != '1)) begin
                hazard_cnt_d = hazard_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trk_q        <= '0;
            stall_cnt_q  <= '0;
            hazard_cnt_q <= '0;
        end else begin
            trk_q        <= trk_d;
            stall_cnt_q  <= stall_cnt_d;
            hazard_cnt_q <= hazard_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign hazard_cnt = hazard_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed bench with a pipeline-occupancy reference model
module tb_hazard_scoreboard;

    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          id_valid = 0, id_reg_en = 0, id_is_load = 0;
    logic [4:0]    id_rd = 0, id_rs1 = 0, id_rs2 = 0;
    logic          id_rs1_used = 0, id_rs2_used = 0;
    logic          flush_id = 0, mem_wait = 0, perf_clr = 0;
    logic          stall_if, bubble_ex;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic [CW-1:0] stall_cnt, hazard_cnt;

    int errors = 0;
    int checks = 0;

    hazard_scoreboard #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rd(id_rd), .id_reg_en(id_reg_en), .id_is_load(id_is_load),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .flush_id(flush_id), .mem_wait(mem_wait), .perf_clr(perf_clr),
        .stall_if(stall_if), .bubble_ex(bubble_ex),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cnt(stall_cnt), .hazard_cnt(hazard_cnt)
    );

    always #5 clk = ~clk;

    // Model: which instruction occupies EX/MEM/WB, plus expected counter values.
    logic       mv [3];
    logic [4:0] mrd [3];
    logic       men [3];
    logic       mld [3];
    int         m_stall, m_haz;

    logic [3:0] ea, eb;
    logic       e_haz, e_stall, e_bub;

    // Returns {blocked, select}: first producer found walking from EX toward WB.
    function automatic logic [3:0] src_eval(input logic [4:0] rs, input logic used);
        logic       done;
        logic [3:0] r;
        done = 1'b0;
        r    = '0;
        for (int k = 0; k < 3; k++) begin
            if (!done && used && rs != 0 && mv[k] && men[k] && mrd[k] == rs) begin
                done = 1'b1;
                if (k >= (mld[k] ? 2 : 1)) r[2:0] = 3'(k + 1);
                else r[3] = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        ea      = src_eval(id_rs1, id_rs1_used);
        eb      = src_eval(id_rs2, id_rs2_used);
        e_haz   = id_valid && !flush_id && (ea[3] || eb[3]);
        e_stall = mem_wait || e_haz;
        e_bub   = e_haz && !mem_wait;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                mv[k] <= 0; mrd[k] <= 0; men[k] <= 0; mld[k] <= 0;
            end
            m_stall <= 0;
            m_haz   <= 0;
        end else begin
            if (perf_clr) begin
                m_stall <= 0;
                m_haz   <= 0;
            end else begin
                if (e_stall && m_stall < MAXC) m_stall <= m_stall + 1;
                if (e_bub && m_haz < MAXC) m_haz <= m_haz + 1;
            end
            if (!mem_wait) begin
                for (int k = 2; k > 0; k--) begin
                    mv[k] <= mv[k-1]; mrd[k] <= mrd[k-1]; men[k] <= men[k-1]; mld[k] <= mld[k-1];
                end
                mv[0]  <= !(e_haz || flush_id || !id_valid);
                mrd[0] <= id_rd;
                men[0] <= id_reg_en;
                mld[0] <= id_is_load;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("stall_if", 32'(stall_if), 32'(e_stall));
            chk("bubble_ex", 32'(bubble_ex), 32'(e_bub));
            chk("fwd_a_sel", 32'(fwd_a_sel), 32'(ea[2:0]));
            chk("fwd_b_sel", 32'(fwd_b_sel), 32'(eb[2:0]));
            chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
            chk("hazard_cnt", 32'(hazard_cnt), 32'(m_haz));
        end
    end

    task automatic drive(input logic v, input logic [4:0] rd, input logic en, input logic ld,
                         input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2,
                         input logic fl, input logic mw, input logic clr);
        @(posedge clk);
        #1;
        id_valid = v; id_rd = rd; id_reg_en = en; id_is_load = ld;
        id_rs1 = r1; id_rs2 = r2; id_rs1_used = u1; id_rs2_used = u2;
        flush_id = fl; mem_wait = mw; perf_clr = clr;
    endtask

    task automatic nop(input logic mw, input logic clr);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, mw, clr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_stall_if", 32'(stall_if), 0);
        chk("rst_bubble", 32'(bubble_ex), 0);
        chk("rst_fwd_a", 32'(fwd_a_sel), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_hazard_cnt", 32'(hazard_cnt), 0);
        rst = 1'b1;

        // Empty tracker: no stall, regfile select.
        drive(1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0);
        #3 chk("t1_stall", 32'(stall_if), 0);
        chk("t1_fwd_a", 32'(fwd_a_sel), 0);

        // ADD x5 then BEQ x5,x0: one bubble, then forward from MEM.
        drive(1, 5, 1, 0, 1, 2, 1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 5, 0, 1, 1, 0, 0, 0);
        #3 chk("t2_bubble", 32'(bubble_ex), 1);
        drive(1, 0, 0, 0, 5, 0, 1, 1, 0, 0, 0);
        #3 chk("t2_fwd_a", 32'(fwd_a_sel), 2);
        chk("t2_hazard_cnt", 32'(hazard_cnt), 1);
        nop(0, 1);

        // LW x7 then ADD x8,x7,x7: two bubbles, then forward from WB.
        drive(1, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 8, 1, 0, 7, 7, 1, 1, 0, 0, 0);
        #3 chk("t3_bubble", 32'(bubble_ex), 1);
        drive(1, 8, 1, 0, 7, 7, 1, 1, 0, 0, 0);
        drive(1, 8, 1, 0, 7, 7, 1, 1, 0, 0, 0);
        #3 chk("t3_fwd_a", 32'(fwd_a_sel), 3);
        chk("t3_fwd_b", 32'(fwd_b_sel), 3);
        chk("t3_hazard_cnt", 32'(hazard_cnt), 2);
        chk("t3_stall_cnt", 32'(stall_cnt), 2);

        // SUB x3 at WB, ADD x3 at MEM: youngest producer wins.
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        nop(0, 0);
        drive(1, 0, 0, 0, 0, 3, 0, 1, 0, 0, 1);
        #3 chk("t4_fwd_b", 32'(fwd_b_sel), 2);
        chk("t4_stall", 32'(stall_if), 0);

        // LW x9 in EX with consumer frozen by mem_wait for three cycles.
        drive(1, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 9, 0, 1, 0, 0, 1, 0);
        #3 chk("t5_stall", 32'(stall_if), 1);
        chk("t5_bubble", 32'(bubble_ex), 0);
        drive(1, 0, 0, 0, 9, 0, 1, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 9, 0, 1, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 9, 0, 1, 0, 0, 0, 0);
        #3 chk("t5_resume_bubble", 32'(bubble_ex), 1);
        chk("t5_stall_cnt", 32'(stall_cnt), 3);
        chk("t5_hazard_cnt", 32'(hazard_cnt), 0);
        drive(1, 0, 0, 0, 9, 0, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 9, 0, 1, 0, 0, 0, 0);
        #3 chk("t5_fwd_a", 32'(fwd_a_sel), 3);
        chk("t5_hazard_cnt2", 32'(hazard_cnt), 2);
        chk("t5_stall_cnt2", 32'(stall_cnt), 5);

        // Load into x0 never matches; flush beats a hazard and inserts nothing.
        drive(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        #3 chk("t6_x0_stall", 32'(stall_if), 0);
        chk("t6_x0_fwd_a", 32'(fwd_a_sel), 0);
        drive(1, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 6, 1, 0, 4, 0, 1, 0, 1, 0, 0);
        #3 chk("t6_flush_stall", 32'(stall_if), 0);
        chk("t6_flush_bubble", 32'(bubble_ex), 0);
        drive(1, 0, 0, 0, 6, 0, 1, 0, 0, 0, 0);
        #3 chk("t6_killed_stall", 32'(stall_if), 0);
        chk("t6_killed_fwd", 32'(fwd_a_sel), 0);

        // Long freeze saturates stall_cnt; clear wins over increment.
        repeat (14) nop(1, 0);
        nop(1, 1);
        #3 chk("t7_sat", 32'(stall_cnt), MAXC);
        chk("t7_haz_hold", 32'(hazard_cnt), 2);
        nop(0, 0);
        #3 chk("t7_clr", 32'(stall_cnt), 0);

        // Async reset mid-flight drops the in-flight producer.
        drive(1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        nop(0, 0);
        #1 rst = 1'b0;
        #1 rst = 1'b1;
        drive(1, 0, 0, 0, 10, 0, 1, 0, 0, 0, 0);
        #3 chk("t8_stall", 32'(stall_if), 0);
        chk("t8_fwd_a", 32'(fwd_a_sel), 0);
        nop(0, 0);

        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
